// File: rtl/prog_mem_loader.sv
// Boot-time program memory loader: framed byte stream in, single-cycle word writes out.
// Optional trailing checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module prog_mem_loader #(
    parameter int         DATA_WIDTH     = 32,
    parameter int         MEM_DEPTH      = 2048,
    parameter int         WADDR_WIDTH    = 11,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [WADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] DEPTH_17 = 17'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_FIN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_hdr_cnt;
    logic [1:0]              r_byte_cnt;
    logic [15:0]             r_start;
    logic [15:0]             r_len;
    logic [15:0]             r_gap;
    logic [WADDR_WIDTH-1:0]  r_ptr;
    logic [DATA_WIDTH-9:0]   r_word;
    logic                    r_in_ready;
    logic                    r_wr_en;
    logic [WADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_cpu_hold;
    logic                    r_done;
    logic                    r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              r_sum;
`endif

    logic                    w_acc;
    logic                    w_gap_expired;
    logic [15:0]             w_len;
    logic [16:0]             w_end;

    assign w_acc         = in_valid & r_in_ready;
    assign w_gap_expired = (r_gap == GAP_LAST);
    // LEN high byte arrives on the bus in the same cycle the range check is made
    assign w_len         = {in_data, r_len[7:0]};
    assign w_end         = {1'b0, r_start} + {1'b0, w_len};

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;

    // Frame parser, word assembler and write strobe generator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hdr_cnt  <= 2'd0;
            r_byte_cnt <= 2'd0;
            r_start    <= 16'd0;
            r_len      <= 16'd0;
            r_gap      <= 16'd0;
            r_ptr      <= '0;
            r_word     <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            r_in_ready <= 1'b1;
            r_wr_en    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc && (in_data == SYNC_BYTE)) begin
                        r_state    <= S_HDR;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_gap      <= 16'd0;
                        r_hdr_cnt  <= 2'd0;
                        r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum      <= 8'd0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HDR: begin
                    if (w_acc) begin
                        r_gap     <= 16'd0;
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        case (r_hdr_cnt)
                            2'd0:    r_start[7:0]  <= in_data;
                            2'd1:    r_start[15:8] <= in_data;
                            2'd2:    r_len[7:0]    <= in_data;
                            default: begin
                                r_len[15:8] <= in_data;
                                if ((w_len == 16'd0) || (w_end > DEPTH_17)) begin
                                    r_state <= S_ERR;
                                end else begin
                                    r_state <= S_DATA;
                                    r_ptr   <= r_start[WADDR_WIDTH-1:0];
                                end
                            end
                        endcase
                    end else if (w_gap_expired) begin
                        r_state <= S_ERR;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_gap      <= 16'd0;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_word     <= {r_word[DATA_WIDTH-17:0], in_data};
`ifdef LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + in_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_ptr;
                            r_wr_data <= {r_word, in_data};
                            r_ptr     <= r_ptr + WADDR_WIDTH'(1);
                            r_len     <= r_len - 16'd1;
                            if (r_len == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_state <= S_FIN;
`endif
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else if (w_gap_expired) begin
                        r_state <= S_ERR;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_acc) begin
                        r_gap   <= 16'd0;
                        r_state <= (in_data == r_sum) ? S_FIN : S_ERR;
                    end else if (w_gap_expired) begin
                        r_state <= S_ERR;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
`endif
                S_FIN: begin
                    r_done     <= 1'b1;
                    r_cpu_hold <= 1'b0;
                    r_state    <= S_IDLE;
                end
                S_ERR: begin
                    r_err      <= 1'b1;
                    r_cpu_hold <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_cpu_hold <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed plus randomized frames for prog_mem_loader, checked against a frame-level model.
module tb_prog_mem_loader;

    localparam int         TO    = 400;
    localparam int         DEPTH = 2048;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_mem_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_wr = -100;
    int          spacing_bad = 0;
    logic [42:0] obs_q[$];
    logic [42:0] exp_q[$];
    logic [7:0]  fr_q[$];
    logic [7:0]  pl_q[$];
    logic        exp_done;
    logic        exp_err;

    // Write monitor: logs every strobe and its distance from the previous one
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en === 1'b1) begin
            obs_q.push_back({wr_addr, wr_data});
            if (cyc - last_wr < 4) spacing_bad = spacing_bad + 1;
            last_wr = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Frame model: bytes to send, expected writes and final flags
    task automatic build(input int start, input int len, input bit bad_csum);
        logic [7:0]  sum;
        logic [15:0] s16;
        logic [15:0] l16;
        bit          ok;
        s16 = 16'(start);
        l16 = 16'(len);
        sum = 8'd0;
        fr_q.delete();
        exp_q.delete();
        fr_q.push_back(SYNC);
        fr_q.push_back(s16[7:0]);
        fr_q.push_back(s16[15:8]);
        fr_q.push_back(l16[7:0]);
        fr_q.push_back(l16[15:8]);
        ok = (len != 0) && (start + len <= DEPTH);
        if (ok) begin
            for (int w = 0; w < len; w++) begin
                exp_q.push_back({11'(start + w), pl_q[4*w], pl_q[4*w+1], pl_q[4*w+2], pl_q[4*w+3]});
            end
            for (int i = 0; i < len * 4; i++) begin
                fr_q.push_back(pl_q[i]);
                sum = sum + pl_q[i];
            end
`ifdef LOADER_CHECKSUM_EN
            fr_q.push_back(bad_csum ? (sum ^ 8'h71) : sum);
            exp_done = !bad_csum;
`else
            exp_done = 1'b1;
`endif
        end else begin
            exp_done = 1'b0;
        end
        exp_err = !exp_done;
    endtask

    task automatic rand_payload(input int len);
        pl_q.delete();
        for (int i = 0; i < len * 4; i++) begin
            pl_q.push_back(($urandom_range(3, 0) == 0) ? SYNC : 8'($urandom));
        end
    endtask

    task automatic play(input int max_gap);
        foreach (fr_q[i]) begin
            send(fr_q[i]);
            if (max_gap > 0) tick($urandom_range(max_gap, 0));
        end
        tick(4);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        obs_q.delete();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick(3);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_flags", 64'({cpu_hold, done, err}), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("ready_rise", 64'(in_ready), 64'd1);
        tick(2);

        // Frame A with cycle-exact strobe and hold checks
        pl_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        build(16, 2, 1'b0);
        chk("a_hold_pre", 64'(cpu_hold), 64'd0);
        send(fr_q[0]);
        chk("a_hold_sync", 64'(cpu_hold), 64'd1);
        for (int i = 1; i < 9; i++) send(fr_q[i]);
        chk("a_strobe0", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 11'h010, 32'h12345678}));
        send(fr_q[9]);
        chk("a_strobe_off", 64'(wr_en), 64'd0);
        chk("a_hold_mid", 64'(cpu_hold), 64'd1);
        for (int i = 10; i < fr_q.size(); i++) send(fr_q[i]);
        tick(4);
        check_result("frameA");

        // Range limits and zero length
        pl_q.delete();
        build(12'h7FF, 2, 1'b0);
        play(0);
        check_result("range_over");
        rand_payload(2);
        build(12'h7FE, 2, 1'b0);
        play(0);
        check_result("range_edge");
        build(5, 0, 1'b0);
        play(0);
        check_result("len_zero");
        rand_payload(1);
        build(33, 1, 1'b0);
        play(0);
        check_result("err_clear");

        // Gap timeout: silence just short of the limit is tolerated, past it aborts
        rand_payload(1);
        build(0, 1, 1'b0);
        for (int i = 0; i < 7; i++) send(fr_q[i]);
        tick(TO - 5);
        chk("to_before", 64'({err, cpu_hold}), 64'({1'b0, 1'b1}));
        tick(10);
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b1;
        check_result("timeout");

        // Reset in the middle of the second word
        rand_payload(3);
        build(12'h123, 3, 1'b0);
        for (int i = 0; i < 11; i++) send(fr_q[i]);
        rst = 1'b1;
        tick(1);
        chk("mrst_outs", 64'({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err}), 64'd0);
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) send(8'h00);
        tick(3);
        exp_q = '{exp_q[0]};
        exp_done = 1'b0;
        exp_err  = 1'b0;
        check_result("mid_reset");

        // Garbage before a sync byte
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        rand_payload(1);
        build(0, 1, 1'b0);
        play(0);
        check_result("garbage");

        // Random frames with idle gaps between bytes
        for (int f = 0; f < 8; f++) begin
            int len;
            int start;
            len   = $urandom_range(6, 1);
            start = $urandom_range(DEPTH - len, 0);
            rand_payload(len);
            build(start, len, 1'b0);
            play(2);
            check_result($sformatf("rand%0d", f));
        end

`ifdef LOADER_CHECKSUM_EN
        pl_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        build(16, 2, 1'b1);
        play(0);
        check_result("csum_bad");
`endif

        chk("wr_spacing", 64'(spacing_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
